// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with an elastic valid/ready pipeline.
// Each register stage resolves WIDTH/STAGES result bits (LSB first) using
// BLOCK-bit carry-select blocks. The stage carries forward only the operand
// bits not yet consumed, plus the result bits produced so far.
module pipelined_csel_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = WIDTH / STAGES;
  localparam int NB = SW / BLOCK;

  if (STAGES < 1 || (WIDTH % (BLOCK * STAGES)) != 0) begin : g_param_check
    $error("pipelined_csel_adder: WIDTH must be a multiple of BLOCK*STAGES and STAGES >= 1");
  end

  // One stage's worth of carry-select blocks: both block sums are formed
  // up front and the incoming carry picks one, so the critical path is one
  // block ripple plus a mux per block.
  function automatic logic [SW:0] csel_seg(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b,
                                           input logic          c);
    logic [SW-1:0] s;
    logic          cy;
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    s  = '0;
    cy = c;
    for (int i = 0; i < NB; i++) begin
      r0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]};
      r1 = r0 + {{BLOCK{1'b0}}, 1'b1};
      s[i*BLOCK +: BLOCK] = cy ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
      cy = cy ? r1[BLOCK] : r0[BLOCK];
    end
    return {cy, s};
  endfunction

  // Subtraction folds into addition: invert B and flip the carry-in.
  logic [WIDTH-1:0] be;
  logic             c0;
  assign be = B ^ {WIDTH{sub}};
  assign c0 = cin ^ sub;

  logic [STAGES-1:0] vld_p;
  logic [STAGES:0]   en;
  logic [STAGES-1:0] up_vld;
  logic [STAGES-1:0] ld;

  // Elastic enable chain: a stage advances when it is empty or the stage
  // downstream advances; data registers load only real transactions.
  always_comb begin
    en     = '0;
    up_vld = '0;
    ld     = '0;
    en[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) en[k] = !vld_p[k] || en[k+1];
    up_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) up_vld[k] = vld_p[k-1];
    ld = en[STAGES-1:0] & up_vld;
  end

  // Valid bits move forward wherever the stage is enabled; reset empties the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) vld_p[k] <= up_vld[k];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = vld_p[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;
    localparam int UW = WIDTH - LO;

    logic [UW-1:0] ua;
    logic [UW-1:0] ub;
    logic          c_in;
    logic [SW:0]   seg;
    logic [HI-1:0] s_nxt;
    logic [HI-1:0] s_p;
    logic          c_p;

    if (k == 0) begin : g_src
      assign ua    = A;
      assign ub    = be;
      assign c_in  = c0;
      assign s_nxt = seg[SW-1:0];
    end else begin : g_src
      assign ua    = g_st[k-1].g_mid.ra_p;
      assign ub    = g_st[k-1].g_mid.rb_p;
      assign c_in  = g_st[k-1].c_p;
      assign s_nxt = {seg[SW-1:0], g_st[k-1].s_p};
    end

    assign seg = csel_seg(ua[SW-1:0], ub[SW-1:0], c_in);

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-HI-1:0] ra_p;
      logic [WIDTH-HI-1:0] rb_p;
      // Intermediate stage boundary: partial sum, block carry and unconsumed operand bits.
      always_ff @(posedge clk) begin
        if (ld[k]) begin
          s_p  <= s_nxt;
          c_p  <= seg[SW];
          ra_p <= ua[UW-1:SW];
          rb_p <= ub[UW-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_p;
      // Output stage boundary: registered S/cout/ovf, cleared by reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_p   <= '0;
          c_p   <= 1'b0;
          ovf_p <= 1'b0;
        end else if (ld[k]) begin
          s_p   <= s_nxt;
          c_p   <= seg[SW];
          ovf_p <= (ua[UW-1] == ub[UW-1]) && (seg[SW-1] != ua[UW-1]);
        end
      end
    end
  end

  assign S    = g_st[STAGES-1].s_p;
  assign cout = g_st[STAGES-1].c_p;
  assign ovf  = g_st[STAGES-1].g_last.ovf_p;

endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, pipelined carry-select adder/subtractor that generalises the team's fixed 16-bit, 4-bit-block carry-select adder. Operand width, block size and pipeline depth are set by parameters; an add/subtract mode and a signed-overflow flag are added. A valid/ready handshake with backpressure lets the block sit directly in streaming datapaths. Throughput is one operation per cycle.

## Interface

- WIDTH, 32, operand and result width in bits.
- BLOCK, 4, bits per carry-select block.
- STAGES, 2, number of pipeline register stages.
- Constraint: WIDTH % (BLOCK*STAGES) == 0 and STAGES >= 1. Violation is an elaboration-time error.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry in (add) or borrow in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result this cycle.
- S  out  WIDTH  sum/difference.
- cout  out  1  raw carry out of MSB.
- ovf  out  1  two's-complement signed overflow.

## Operation

- Effective operands: Be = B ^ {WIDTH{sub}}, c0 = cin ^ sub. Result: {cout, S} = A + Be + c0.
  - sub=1, cin=0 gives A-B.
  - sub=1, cin=1 gives A-B-1 (borrow in).
  - In subtract mode cout=1 means no borrow.
- ovf = (A[MSB] == Be[MSB]) && (S[MSB] != A[MSB]).
- Datapath: NBLK = WIDTH/BLOCK blocks; each stage handles NBLK/STAGES consecutive blocks, LSB first.
  - Each block computes two ripple sums (carry-in 0 and 1) and selects by the incoming carry.
  - The least-significant block of the whole adder may be a single ripple adder.
- Stage k register holds: valid bit v[k], carry out of its last block, result bits produced so far, and the unconsumed upper bits of A, Be and sub-derived MSB info for ovf.
- Stage 0 logic reads the input ports directly. Stage k>0 logic reads stage k-1's register.
- The final register drives S, cout, ovf and out_valid. Outputs are registered, never combinational from inputs.
- Elastic flow control:
  - en[STAGES] = out_ready.
  - en[k] = !v[k] || en[k+1].
  - in_ready = en[0].
- When en[k]=1, register k loads the upstream data; v[k] loads the upstream valid (in_valid for k=0). When en[k]=0, register k holds.
- Bubbles collapse: an empty stage accepts data even while the output is stalled.
- Transactions leave in acceptance order. No loss or duplication under any out_ready pattern.

## Timing

- Reset (rst=1 at a rising edge): all v[k]=0, out_valid=0, S=0, cout=0, ovf=0. In-flight data is discarded.
- in_ready is 1 in the cycle after reset deassertion.
- Reset dominates simultaneous in_valid/in_ready: nothing is accepted on a reset edge.
- Acceptance: edge where in_valid && in_ready.
- Latency: accepted at edge t gives out_valid=1 after edge t+STAGES-1, i.e. STAGES cycles. Default: 2.
- Output transfer: edge where out_valid && out_ready.
- While out_valid && !out_ready, S/cout/ovf/out_valid are held stable.
- in_ready depends combinationally on out_ready through the en chain. in_valid must not depend on in_ready.
- Full: with out_ready=0, exactly STAGES transactions are accepted, then in_ready=0.
- Simultaneous pop and push when full: both occur in the same edge. in_ready=1 in a full pipeline when out_ready=1.

## Test plan

- Reset: hold rst 2 cycles with in_valid=1.
  -> out_valid=0, S=0, cout=0, ovf=0 throughout; in_ready=1 first cycle after release; nothing emitted.
- Carry ripple across all blocks and stages (defaults): A=0xFFFFFFFF, B=0x00000001, cin=0, sub=0.
  -> S=0x00000000, cout=1, ovf=0, out_valid exactly 2 cycles after acceptance.
- Subtract and overflow:
  - A=5, B=7, sub=1, cin=0 -> S=0xFFFFFFFE, cout=0, ovf=0.
  - A=0x7FFFFFFF, B=1, add -> S=0x80000000, ovf=1.
  - A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, ovf=1, cout=1.
- Backpressure (defaults): offer 4 back-to-back ops (A=1..4, B=0x10) with out_ready=0.
  -> 2 accepted, then in_ready=0; outputs held.
  -> Raise out_ready: results 0x11, 0x12, 0x13, 0x14 in order, one per cycle, none lost or duplicated.
- Reset mid-stream: assert rst with 2 ops in flight.
  -> out_valid=0 the next cycle; the in-flight results never appear.
- Randomised: 10k ops, random in_valid/out_ready/sub/cin, for (WIDTH,BLOCK,STAGES) = (16,4,1), (32,4,2), (64,8,4).
  -> every output equals the reference model {cout,S}=A+Be+c0 and the ovf formula; order preserved.
